spi_master_engine: RTL and testbench
====================================

// Module: spi_master_engine
// PURPOSE
//  SPI initiator (mode 0: CPOL=0, CPHA=0) that drives the chip's SPI minion ports.
//  Used in test harnesses and on the host-side FPGA; it also serves as the reusable
//  master core inside future interconnects.
//  Takes one NBITS-wide word over a val/rdy stream, shifts it out MSB-first on MOSI,
//  and captures MISO in parallel. Returns the received word and its parity over a
//  second val/rdy stream.
// PARAMETERS
//  NBITS   32  bits per transaction (chip select held low for exactly NBITS SCLK pulses)
//  DIV_W   8   width of the half_div input
// PORTS
//  clk        in   1      system clock; all logic is synchronous to its rising edge
//  reset      in   1      asynchronous, active-low reset
//  half_div   in   DIV_W  SCLK half-period minus 1, in clk cycles; latched when send is accepted
//  send_val   in   1      send_msg is valid
//  send_rdy   out  1      engine idle, can accept a word
//  send_msg   in   NBITS  word to transmit
//  recv_val   out  1      recv_msg/recv_parity valid
//  recv_rdy   in   1      consumer accepts recv_msg
//  recv_msg   out  NBITS  word captured from MISO
//  recv_parity out 1      XOR of all recv_msg bits
//  spi_cs     out  1      chip select, active low
//  spi_sclk   out  1      serial clock, idle low
//  spi_mosi   out  1      serial data out
//  spi_miso   in   1      serial data in; sampled, not synchronised (harness drives it synchronously)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, spi_cs=1, spi_sclk=0, spi_mosi=0, recv_val=0,
//   recv_msg=0, recv_parity=0, bit counter=0, divider counter=0. Hence send_rdy=1.
//  H = latched half_div+1. Every timed state lasts exactly H clk cycles.
//  States:
//   IDLE:  send_rdy=1. On send_val: latch send_msg and half_div -> SETUP.
//          In the same edge: spi_cs<=0, spi_mosi<=send_msg[NBITS-1].
//   SETUP: cs low, sclk low, H cycles -> HIGH.
//   HIGH:  on entry edge, spi_sclk<=1 and shift spi_miso into recv shift reg LSB.
//          After H cycles: if bits sent < NBITS -> LOW, else -> HOLD.
//   LOW:   on entry edge, spi_sclk<=0 and spi_mosi<=next bit (MSB-first). After H cycles -> HIGH.
//   HOLD:  sclk low, cs low, H cycles. On exit edge: spi_cs<=1, spi_mosi<=0,
//          recv_msg<=shift reg, recv_parity<=^shift reg, recv_val<=1 -> DONE.
//   DONE:  recv_val=1, send_rdy=0. recv_msg/parity held stable. On recv_rdy: recv_val<=0 -> IDLE.
//  Latency:
//   - recv_val rises H*(2*NBITS+1) clk edges after the accepting edge.
//   - Exactly NBITS SCLK rising edges per transaction.
//   - MOSI is stable for H cycles before each rising edge and after it.
//  send_rdy = (state==IDLE), combinational from state; it is never asserted in DONE.
//   In DONE, recv_rdy and send_val high in the same cycle: only recv completes.
//   send is accepted on a later IDLE cycle (min 1 idle cycle between transactions).
//  half_div and send_msg changes after acceptance have no effect on the current transaction.
//  half_div=0 is legal (SCLK = clk/2). half_div=all-ones: H=2^DIV_W, with no counter overflow
//   (counter is DIV_W+1 bits or compares against half_div).
//  Reset asserted mid-transaction: spi_cs returns to 1 and spi_sclk to 0 immediately (async).
//   Partial data is discarded and no recv_val is produced.
//  spi_sclk, spi_cs and spi_mosi are driven directly from flops (glitch-free).
// TESTING (NBITS=32 unless noted; loopback = spi_miso tied to spi_mosi)
//  1. Reset held -> spi_cs=1, spi_sclk=0, spi_mosi=0, recv_val=0, send_rdy=1. Check during and after release.
//  2. Loopback, half_div=0, send 0xA5A50F0F, recv_rdy=1 ->
//     recv_msg=0xA5A50F0F, recv_parity=0, recv_val rises 65 edges after accept, 32 SCLK pulses.
//  3. NBITS=8, half_div=3, miso driven 0x3C MSB-first off SCLK falling edge ->
//     SCLK high/low phases 4 cycles each; recv_msg=0x3C, parity=0; recv_val 68 edges after accept.
//  4. Loopback 0x00000001, recv_rdy=0 for 20 cycles while send_val=1 ->
//     recv_val held, msg stable, send_rdy=0, cs stays 1.
//     Then recv_rdy=1 -> IDLE; the second word is accepted the next cycle.
//  5. Assert reset at the 10th SCLK rise ->
//     cs=1, sclk=0 without a clk edge. After release: send_rdy=1, no recv_val.
//     A new transaction completes correctly.
//  6. Loopback 0x80000000 then 0xFFFFFFFE back-to-back ->
//     parities 1 then 1; recv_msg values match; half_div changed mid-word has no effect.

Source files
------------

// File: rtl/spi_master_engine.sv
// SPI mode-0 initiator: shifts one NBITS word out MSB-first on MOSI while capturing MISO,
// then returns the captured word and its parity over a val/rdy stream.
module spi_master_engine #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] half_div,
  input  logic             send_val,
  output logic             send_rdy,
  input  logic [NBITS-1:0] send_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
  output logic [NBITS-1:0] recv_msg,
  output logic             recv_parity,
  output logic             spi_cs,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int unsigned BCW = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [BCW-1:0]   bits_q, bits_d;
  logic [NBITS-1:0] tx_q, tx_d;
  logic [NBITS-1:0] rx_q, rx_d;
  logic [NBITS-1:0] msg_q, msg_d;
  logic             par_q, par_d;
  logic             val_q, val_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             phase_end;

  // Counter runs 0..half_q, so H = half_q+1 never overflows DIV_W bits.
  assign phase_end = (cnt_q == half_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      half_q  <= '0;
      cnt_q   <= '0;
      bits_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      msg_q   <= '0;
      par_q   <= 1'b0;
      val_q   <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      msg_q   <= msg_d;
      par_q   <= par_d;
      val_q   <= val_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    msg_d   = msg_q;
    par_d   = par_q;
    val_d   = val_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;

    case (state_q)
      ST_IDLE: begin
        if (send_val) begin
          half_d  = half_div;
          tx_d    = {send_msg[NBITS-2:0], 1'b0};
          rx_d    = '0;
          bits_d  = '0;
          cnt_d   = '0;
          cs_d    = 1'b0;
          mosi_d  = send_msg[NBITS-1];
          state_d = ST_SETUP;
        end
      end

      // Both phases end with a rising SCLK edge that samples MISO.
      ST_SETUP, ST_LOW: begin
        if (phase_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[NBITS-2:0], spi_miso};
          bits_d  = bits_q + BCW'(1);
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      ST_HIGH: begin
        if (phase_end) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bits_q < BCW'(NBITS)) begin
            mosi_d  = tx_q[NBITS-1];
            tx_d    = {tx_q[NBITS-2:0], 1'b0};
            state_d = ST_LOW;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      ST_HOLD: begin
        if (phase_end) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          msg_d   = rx_q;
          par_d   = ^rx_q;
          val_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end

      ST_DONE: begin
        if (recv_rdy) begin
          val_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign send_rdy    = (state_q == ST_IDLE);
  assign recv_val    = val_q;
  assign recv_msg    = msg_q;
  assign recv_parity = par_q;
  assign spi_cs      = cs_q;
  assign spi_sclk    = sclk_q;
  assign spi_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed bench for spi_master_engine: a 32-bit loopback instance and an 8-bit instance
// whose MISO is driven from a pattern off the falling SCLK edge.
module tb_spi_master_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  half_div;
  logic        recv_rdy;

  logic        send_val32, send_rdy32, recv_val32, recv_par32, cs32, sclk32, mosi32;
  logic [31:0] send_msg32, recv_msg32;
  wire         miso32 = mosi32;

  logic        send_val8, send_rdy8, recv_val8, recv_par8, cs8, sclk8, mosi8, miso8;
  logic [7:0]  send_msg8, recv_msg8;

  logic        sel8;
  wire         cs_m   = sel8 ? cs8 : cs32;
  wire         sclk_m = sel8 ? sclk8 : sclk32;
  wire         val_m  = sel8 ? recv_val8 : recv_val32;

  int errors = 0;
  int checks = 0;

  spi_master_engine #(.NBITS(32), .DIV_W(8)) u32 (
    .clk(clk), .reset(reset), .half_div(half_div),
    .send_val(send_val32), .send_rdy(send_rdy32), .send_msg(send_msg32),
    .recv_val(recv_val32), .recv_rdy(recv_rdy), .recv_msg(recv_msg32), .recv_parity(recv_par32),
    .spi_cs(cs32), .spi_sclk(sclk32), .spi_mosi(mosi32), .spi_miso(miso32)
  );

  spi_master_engine #(.NBITS(8), .DIV_W(8)) u8 (
    .clk(clk), .reset(reset), .half_div(half_div),
    .send_val(send_val8), .send_rdy(send_rdy8), .send_msg(send_msg8),
    .recv_val(recv_val8), .recv_rdy(recv_rdy), .recv_msg(recv_msg8), .recv_parity(recv_par8),
    .spi_cs(cs8), .spi_sclk(sclk8), .spi_mosi(mosi8), .spi_miso(miso8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts one word and runs until recv_val; 8-bit runs drive pattern msg[7:0] on MISO.
  task automatic run_txn(input bit s8, input logic [31:0] msg, input logic [7:0] hd,
                         input logic [7:0] hd_after, output int edges, output int pulses,
                         output bit phase_ok);
    int h, run, bound, idx;
    logic prev, cur;
    logic [7:0] pat;
    h = int'(hd) + 1;
    bound = h * 65 + 50;
    edges = 0;
    pulses = 0;
    phase_ok = 1'b1;
    run = 1;
    idx = 0;
    pat = msg[7:0];
    @(negedge clk);
    sel8 = s8;
    half_div = hd;
    if (s8) begin
      send_val8 = 1'b1;
      send_msg8 = ~pat;
      miso8 = pat[7];
    end else begin
      send_val32 = 1'b1;
      send_msg32 = msg;
    end
    @(posedge clk); #1;
    chk("accept_cs", 32'(cs_m), 32'd0);
    send_val32 = 1'b0;
    send_val8 = 1'b0;
    half_div = hd_after;
    send_msg32 = ~send_msg32;
    send_msg8 = ~send_msg8;
    prev = sclk_m;
    while (edges < bound && !val_m) begin
      @(posedge clk); #1;
      edges++;
      cur = sclk_m;
      if (cur == prev) run++;
      else begin
        if (run != h) phase_ok = 1'b0;
        run = 1;
      end
      if (!prev && cur) pulses++;
      if (s8 && prev && !cur && idx < 7) begin
        idx++;
        miso8 = pat[7 - idx];
      end
      prev = cur;
    end
    chk("done_in_budget", 32'(val_m), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, p;
    bit ok, seen;
    logic prev;

    reset = 1'b0;
    recv_rdy = 1'b1;
    half_div = '0;
    send_val32 = 1'b0;
    send_msg32 = '0;
    send_val8 = 1'b0;
    send_msg8 = '0;
    miso8 = 1'b0;
    sel8 = 1'b0;

    // Reset held, then released
    repeat (3) @(negedge clk);
    chk("rst_cs", 32'(cs32), 32'd1);
    chk("rst_sclk", 32'(sclk32), 32'd0);
    chk("rst_mosi", 32'(mosi32), 32'd0);
    chk("rst_recv_val", 32'(recv_val32), 32'd0);
    chk("rst_send_rdy", 32'(send_rdy32), 32'd1);
    chk("rst_cs8", 32'(cs8), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_cs", 32'(cs32), 32'd1);
    chk("post_rst_sclk", 32'(sclk32), 32'd0);
    chk("post_rst_send_rdy", 32'(send_rdy32), 32'd1);
    chk("post_rst_recv_val", 32'(recv_val32), 32'd0);

    // Loopback, H=1
    run_txn(1'b0, 32'hA5A50F0F, 8'd0, 8'd0, e, p, ok);
    chk("t2_latency", 32'(e), 32'd65);
    chk("t2_pulses", 32'(p), 32'd32);
    chk("t2_phases", 32'(ok), 32'd1);
    chk("t2_msg", recv_msg32, 32'hA5A50F0F);
    chk("t2_parity", 32'(recv_par32), 32'd0);
    @(posedge clk); #1;
    chk("t2_val_drop", 32'(recv_val32), 32'd0);
    chk("t2_idle", 32'(send_rdy32), 32'd1);
    chk("t2_msg_hold", recv_msg32, 32'hA5A50F0F);

    // 8-bit, H=4, MISO pattern 0x3C
    run_txn(1'b1, 32'h3C, 8'd3, 8'd0, e, p, ok);
    chk("t3_latency", 32'(e), 32'd68);
    chk("t3_pulses", 32'(p), 32'd8);
    chk("t3_phases", 32'(ok), 32'd1);
    chk("t3_msg", 32'(recv_msg8), 32'h3C);
    chk("t3_parity", 32'(recv_par8), 32'd0);
    @(posedge clk); #1;

    // 8-bit, half_div all-ones: H=256
    run_txn(1'b1, 32'h81, 8'hFF, 8'h00, e, p, ok);
    chk("tmax_latency", 32'(e), 32'd4352);
    chk("tmax_pulses", 32'(p), 32'd8);
    chk("tmax_phases", 32'(ok), 32'd1);
    chk("tmax_msg", 32'(recv_msg8), 32'h81);
    chk("tmax_parity", 32'(recv_par8), 32'd0);
    @(posedge clk); #1;
    sel8 = 1'b0;

    // Backpressure on recv while a new send is pending
    recv_rdy = 1'b0;
    run_txn(1'b0, 32'h00000001, 8'd0, 8'd0, e, p, ok);
    chk("t4_latency", 32'(e), 32'd65);
    chk("t4_parity", 32'(recv_par32), 32'd1);
    send_val32 = 1'b1;
    send_msg32 = 32'h00000003;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_val", 32'(recv_val32), 32'd1);
      chk("t4_hold_msg", recv_msg32, 32'h00000001);
      chk("t4_hold_rdy", 32'(send_rdy32), 32'd0);
      chk("t4_hold_cs", 32'(cs32), 32'd1);
    end
    recv_rdy = 1'b1;
    @(posedge clk); #1;
    chk("t4_consumed", 32'(recv_val32), 32'd0);
    chk("t4_idle", 32'(send_rdy32), 32'd1);
    chk("t4_not_yet_cs", 32'(cs32), 32'd1);
    @(posedge clk); #1;
    chk("t4_accept_cs", 32'(cs32), 32'd0);
    chk("t4_accept_rdy", 32'(send_rdy32), 32'd0);
    send_val32 = 1'b0;
    e = 0;
    while (!recv_val32 && e < 200) begin
      @(posedge clk); #1;
      e++;
    end
    chk("t4b_latency", 32'(e), 32'd65);
    chk("t4b_msg", recv_msg32, 32'h00000003);
    chk("t4b_parity", 32'(recv_par32), 32'd0);
    @(posedge clk); #1;

    // Async reset at the 10th SCLK rise
    @(negedge clk);
    half_div = 8'd1;
    send_val32 = 1'b1;
    send_msg32 = 32'h12345678;
    @(posedge clk); #1;
    send_val32 = 1'b0;
    p = 0;
    e = 0;
    prev = sclk32;
    while (p < 10 && e < 500) begin
      @(posedge clk); #1;
      e++;
      if (!prev && sclk32) p++;
      prev = sclk32;
    end
    chk("t5_rises", 32'(p), 32'd10);
    chk("t5_sclk_hi", 32'(sclk32), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t5_async_cs", 32'(cs32), 32'd1);
    chk("t5_async_sclk", 32'(sclk32), 32'd0);
    chk("t5_async_mosi", 32'(mosi32), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (recv_val32) seen = 1'b1;
    end
    chk("t5_no_recv", 32'(seen), 32'd0);
    chk("t5_send_rdy", 32'(send_rdy32), 32'd1);
    run_txn(1'b0, 32'hC3C35A5A, 8'd1, 8'd1, e, p, ok);
    chk("t5_latency", 32'(e), 32'd130);
    chk("t5_msg", recv_msg32, 32'hC3C35A5A);
    chk("t5_parity", 32'(recv_par32), 32'd0);
    @(posedge clk); #1;

    // Back-to-back words with half_div changed mid-word
    run_txn(1'b0, 32'h80000000, 8'd1, 8'd7, e, p, ok);
    chk("t6a_latency", 32'(e), 32'd130);
    chk("t6a_pulses", 32'(p), 32'd32);
    chk("t6a_phases", 32'(ok), 32'd1);
    chk("t6a_msg", recv_msg32, 32'h80000000);
    chk("t6a_parity", 32'(recv_par32), 32'd1);
    @(posedge clk); #1;
    run_txn(1'b0, 32'hFFFFFFFE, 8'd2, 8'd0, e, p, ok);
    chk("t6b_latency", 32'(e), 32'd195);
    chk("t6b_pulses", 32'(p), 32'd32);
    chk("t6b_phases", 32'(ok), 32'd1);
    chk("t6b_msg", recv_msg32, 32'hFFFFFFFE);
    chk("t6b_parity", 32'(recv_par32), 32'd1);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
